// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, frame-atomic sharing of one byte UART
// between two requesters. Optional forced release: UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 4800
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic [1:0] grant,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        DRAIN
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] grant_nxt;
    // 1 means requester 1 won last, so requester 0 has priority
    logic       last_winner;
    logic       last_winner_nxt;
    logic       last_q;
    logic       owner_valid;
    logic [7:0] owner_data;
    logic       owner_last;
    logic       accept;
    logic       force_release;

    assign owner_valid = (grant[0] & req0_valid) | (grant[1] & req1_valid);
    assign owner_data  = grant[1] ? req1_data : req0_data;
    assign owner_last  = grant[1] ? req1_last : req0_last;
    assign accept      = (state == LOAD) && owner_valid && !tx_busy;

    // state, ownership and the byte/last latch handed to the transmitter
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= 2'b00;
            last_winner <= 1'b1;
            tx_data     <= 8'h00;
            last_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            last_winner <= last_winner_nxt;
            if (accept) begin
                tx_data <= owner_data;
                last_q  <= owner_last;
            end
        end
    end

    // next state, arbitration and handshake outputs
    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        last_winner_nxt = last_winner;
        req0_ready      = 1'b0;
        req1_ready      = 1'b0;
        tx_start        = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) begin
                        grant_nxt = last_winner ? 2'b01 : 2'b10;
                    end else begin
                        grant_nxt = req0_valid ? 2'b01 : 2'b10;
                    end
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                req0_ready = grant[0] && !tx_busy;
                req1_ready = grant[1] && !tx_busy;
                if (accept) begin
                    state_nxt = START;
                    if (owner_last) begin
                        last_winner_nxt = grant[1];
                    end
                end else if (force_release) begin
                    state_nxt       = IDLE;
                    grant_nxt       = 2'b00;
                    last_winner_nxt = grant[1];
                end
            end
            START: begin
                tx_start  = 1'b1;
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        state_nxt = IDLE;
                        grant_nxt = 2'b00;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] idle_cnt;

    assign force_release = (state == LOAD) && !owner_valid &&
                           (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

    // counts consecutive LOAD cycles in which the owner has nothing to send
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (state != LOAD || owner_valid || force_release) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + CW'(1);
        end
    end

    // single-cycle pulse coinciding with the grant dropping to 00
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            timeout <= 1'b0;
        end else begin
            timeout <= force_release;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign force_release      = 1'b0;
    assign timeout            = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 4800, idle-owner cycles before forced release (100 us at 48 MHz).
REQ-002 clk_48mhz  in  1  sole clock, rising edge.
REQ-003 reset_n  in  1  asynchronous assert, active-low reset.
REQ-004 req0_valid / req1_valid  in  1  requester has a byte.
REQ-005 req0_data / req1_data  in  8  byte to send.
REQ-006 req0_last / req1_last  in  1  byte ends requester's frame.
REQ-007 req0_ready / req1_ready  out  1  byte accepted when valid and ready both high.
REQ-008 tx_data  out  8  byte to UART transmitter, registered.
REQ-009 tx_start  out  1  one-cycle start pulse to transmitter.
REQ-010 tx_busy  in  1  transmitter busy; rises no later than the cycle after tx_start.
REQ-011 grant  out  2  one-hot current owner; 2'b00 when unowned.
REQ-012 timeout  out  1  one-cycle pulse on forced release.

Function
REQ-013 States SHALL be IDLE, LOAD, START, DRAIN.
REQ-014 IDLE: grant=00; if any valid, pick owner, set grant, go LOAD next cycle.
REQ-015 Arbitration SHALL be round-robin: both valid -> requester not in last_winner wins; one valid -> it wins.
REQ-016 last_winner SHALL update when the owner's last byte is accepted or on forced release.
REQ-017 LOAD: owner ready = ~tx_busy (combinational); non-owner ready SHALL be 0 in every state.
REQ-018 On accept in LOAD: latch data into tx_data, latch last flag, go START.
REQ-019 START: tx_start=1 for exactly one cycle; go DRAIN. Latency: accept at cycle N -> tx_start high at N+1.
REQ-020 DRAIN: hold until tx_busy==0; then IDLE if latched last else LOAD.
REQ-021 Grant SHALL be held through the whole frame; owner dropping valid in LOAD keeps grant (subject to REQ-026).
REQ-022 tx_data SHALL hold its value until the next accept.
REQ-023 Requester valid arriving while the other owns the bus SHALL wait; no byte interleaving between frames.
REQ-024 tx_busy high in IDLE SHALL not block arbitration; LOAD stalls ready until busy low.

Reset
REQ-025 reset_n low SHALL immediately force: state IDLE, grant 00, tx_start 0, tx_data 8'h00, both ready 0, timeout 0, last_winner = requester 1 (so requester 0 wins first), timeout counter 0; mid-frame reset abandons the frame.

Configuration
REQ-026 With UART_ARB_TIMEOUT_EN defined: in LOAD, counter increments each cycle owner valid is low, clears on owner valid; reaching TIMEOUT_CYCLES -> pulse timeout, grant 00, go IDLE.
REQ-027 Without UART_ARB_TIMEOUT_EN: no counter logic; timeout tied 0; grant held indefinitely until last byte.

Verification
REQ-028 Single frame: req0 sends 8'h41,8'h42(last), busy 10 cycles each -> two tx_start pulses, tx_data 41 then 42, grant 01 then 00.
REQ-029 Contention after reset: req0 and req1 valid same cycle -> grant 01 first; after req0 last byte, grant 10 without idle byte loss.
REQ-030 Fairness: both continuously sending 1-byte frames -> grant alternates 01,10,01,10.
REQ-031 No interleave: req1 valid during req0 3-byte frame -> req1_ready stays 0 until req0 last byte DRAIN completes.
REQ-032 Reset mid-frame: reset_n low in DRAIN -> grant 00, tx_start 0 same cycle; after release req0 wins.
REQ-033 Timeout (macro on, TIMEOUT_CYCLES=16): req0 sends non-last byte then drops valid -> timeout pulse after 16 cycles in LOAD, grant 00; macro off -> grant stays 01.
